// File: rtl/pawn_pst_scanner.sv
// pawn_pst_scanner
//
// Walks all 64 squares of a latched pawn position, one square per clock,
// and accumulates a signed piece-square score from the pawn map table bus.
// White pawns add their table entry directly. Black pawns subtract the
// entry of the rank-mirrored square (sq ^ 56), so a symmetric position
// scores zero.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   start       scan request, honoured only while idle
//   whitePawns  white pawn bitboard (bit i = square i, rank = i>>3)
//   blackPawns  black pawn bitboard, same indexing
//   pstData     64 signed entries of ENTRY_W bits; square i at [ENTRY_W*i +: ENTRY_W]
//   busy        high while scanning and during the completion cycle
//   done        one-cycle pulse when score/pawnCount/conflict are updated
//   score       white sum minus black sum (signed)
//   pawnCount   number of non-conflicting pawns counted
//   conflict    set if any square held both a white and a black pawn
module pawn_pst_scanner #(
  parameter int SCORE_W = 12,
  parameter int ENTRY_W = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [63:0]               whitePawns,
  input  logic [63:0]               blackPawns,
  input  logic [64*ENTRY_W-1:0]     pstData,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] score,
  output logic [4:0]                pawnCount,
  output logic                      conflict
);

  localparam int EXT_W = SCORE_W - ENTRY_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [5:0]                r_sq;
  logic [63:0]               r_white;
  logic [63:0]               r_black;
  logic signed [SCORE_W-1:0] r_acc;
  logic [4:0]                r_count;
  logic                      r_conflict;

  logic                      r_done;
  logic signed [SCORE_W-1:0] r_score;
  logic [4:0]                r_pawnCount;
  logic                      r_conflictOut;

  logic [ENTRY_W-1:0]        w_table [64];
  logic [ENTRY_W-1:0]        w_whiteEntry;
  logic [ENTRY_W-1:0]        w_blackEntry;
  logic signed [SCORE_W-1:0] w_whiteExt;
  logic signed [SCORE_W-1:0] w_blackExt;
  logic                      w_whiteBit;
  logic                      w_blackBit;
  logic                      w_accept;
  logic                      w_busy;

  // Slice the flat table bus into per-square entries so the scan index can
  // select one directly.
  for (genvar gi = 0; gi < 64; gi++) begin : g_table
    assign w_table[gi] = pstData[gi*ENTRY_W +: ENTRY_W];
  end

  // Black squares use the rank-mirrored entry: flipping the three rank bits
  // maps black's view of the board onto white's table layout.
  assign w_whiteEntry = w_table[r_sq];
  assign w_blackEntry = w_table[r_sq ^ 6'd56];
  assign w_whiteExt   = {{EXT_W{w_whiteEntry[ENTRY_W-1]}}, w_whiteEntry};
  assign w_blackExt   = {{EXT_W{w_blackEntry[ENTRY_W-1]}}, w_blackEntry};
  assign w_whiteBit   = r_white[r_sq];
  assign w_blackBit   = r_black[r_sq];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a start request only has an effect from IDLE, so a
  // start seen during SCAN or DONE is simply dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = SCAN;
      SCAN:    if (r_sq == 6'd63) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic decoded from the state.
  always_comb begin
    w_accept = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      IDLE:    w_accept = start;
      SCAN:    w_busy   = 1'b1;
      DONE:    w_busy   = 1'b1;
      default: w_busy   = 1'b0;
    endcase
  end

  // Scan datapath: bitboards are captured once at acceptance so later input
  // changes cannot disturb the scan. A square holding both colours is
  // flagged and otherwise ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sq       <= '0;
      r_white    <= '0;
      r_black    <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else if (w_accept) begin
      r_sq       <= '0;
      r_white    <= whitePawns;
      r_black    <= blackPawns;
      r_acc      <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else if (r_state == SCAN) begin
      r_sq <= r_sq + 6'd1;
      if (w_whiteBit && w_blackBit) begin
        r_conflict <= 1'b1;
      end else if (w_whiteBit) begin
        r_acc   <= r_acc + w_whiteExt;
        r_count <= r_count + 5'd1;
      end else if (w_blackBit) begin
        r_acc   <= r_acc - w_blackExt;
        r_count <= r_count + 5'd1;
      end
    end
  end

  // Result registers: published together with the done pulse and held until
  // the next completion, so a reset mid-scan leaves them cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done        <= 1'b0;
      r_score       <= '0;
      r_pawnCount   <= '0;
      r_conflictOut <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_score       <= r_acc;
        r_pawnCount   <= r_count;
        r_conflictOut <= r_conflict;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign score     = r_score;
  assign pawnCount = r_pawnCount;
  assign conflict  = r_conflictOut;

endmodule

// File: tb/tb_pawn_pst_scanner.sv
module tb_pawn_pst_scanner;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [63:0]       whitePawns;
  logic [63:0]       blackPawns;
  logic [383:0]      pstData;
  logic              busy;
  logic              done;
  logic signed [11:0] score;
  logic [4:0]        pawnCount;
  logic              conflict;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  pawn_pst_scanner #(.SCORE_W(12), .ENTRY_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .whitePawns (whitePawns),
    .blackPawns (blackPawns),
    .pstData    (pstData),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .pawnCount  (pawnCount),
    .conflict   (conflict)
  );

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Called at a negedge. Requests a scan and waits (bounded) for done,
  // counting cycles from the start edge and cycles with busy high. With
  // disturb set, inputs are scrambled and start re-pulsed mid-scan.
  task automatic applyStimulus(input logic [63:0] w, input logic [63:0] b, input bit disturb,
                               output int latency, output int busyCycles);
    whitePawns = w;
    blackPawns = b;
    start      = 1'b1;
    latency    = 0;
    busyCycles = 0;
    while (latency < 200) begin
      @(negedge clk);
      latency++;
      if (latency == 1) start = 1'b0;
      if (disturb && latency == 10) begin
        whitePawns = ~whitePawns;
        blackPawns = ~blackPawns;
        start      = 1'b1;
      end
      if (disturb && latency == 11) start = 1'b0;
      if (busy) busyCycles++;
      if (done) break;
    end
  endtask

  task automatic runScan(input string tag, input logic [63:0] w, input logic [63:0] b,
                         input int expScore, input int expCount, input int expConflict,
                         input bit disturb);
    int lat;
    int bc;
    int extra;
    applyStimulus(w, b, disturb, lat, bc);
    checkOutput({tag, ".latency"}, lat, 66);
    checkOutput({tag, ".busyCycles"}, bc, 65);
    checkOutput({tag, ".score"}, int'(score), expScore);
    checkOutput({tag, ".pawnCount"}, int'(pawnCount), expCount);
    checkOutput({tag, ".conflict"}, int'(conflict), expConflict);
    @(negedge clk);
    checkOutput({tag, ".donePulseWidth"}, int'(done), 0);
    checkOutput({tag, ".scoreHold"}, int'(score), expScore);
    if (disturb) begin
      extra = 0;
      repeat (80) begin
        @(negedge clk);
        if (done) extra++;
      end
      checkOutput({tag, ".extraDone"}, extra, 0);
      checkOutput({tag, ".busyAfter"}, int'(busy), 0);
    end
  endtask

  // Table: rank 1 has mixed entries (square 12 = -32), rank 6 ramps
  // 5,10,15,20,20,15,10,5, square 27 = 9, square 35 = 12, rest = 1.
  task automatic loadTable();
    logic [5:0] v;
    int rank1 [8] = '{3, -4, 7, -9, -32, 9, 4, -3};
    int rank6 [8] = '{5, 10, 15, 20, 20, 15, 10, 5};
    for (int i = 0; i < 64; i++) begin
      v = 6'd1;
      if (i >= 8 && i < 16) v = 6'(rank1[i-8]);
      if (i >= 48 && i < 56) v = 6'(rank6[i-48]);
      if (i == 27) v = 6'd9;
      if (i == 35) v = 6'd12;
      pstData[i*6 +: 6] = v;
    end
  endtask

  initial begin
    int dones;
    int gap;
    reset_n    = 1'b0;
    start      = 1'b0;
    whitePawns = '0;
    blackPawns = '0;
    pstData    = '0;
    loadTable();
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.score", int'(score), 0);
    checkOutput("reset.pawnCount", int'(pawnCount), 0);
    checkOutput("reset.conflict", int'(conflict), 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] initial position");
    runScan("initial", 64'h0000_0000_0000_FF00, 64'h00FF_0000_0000_0000, 0, 16, 0, 1'b0);
    $display("[TB] single pawns");
    runScan("singleWhite", 64'h0000_0000_0000_1000, 64'h0, -32, 1, 0, 1'b0);
    runScan("singleBlack", 64'h0, 64'h0010_0000_0000_0000, 32, 1, 0, 1'b0);
    runScan("mixedPair", 64'h0000_0000_0000_1000, 64'h0010_0000_0000_0000, 0, 2, 0, 1'b0);
    $display("[TB] advanced rank");
    runScan("advanced", 64'h00FF_0000_0000_0000, 64'h0, 100, 8, 0, 1'b0);
    $display("[TB] conflict square");
    runScan("conflict", 64'h0000_0008_0800_0000, 64'h0000_0000_0800_0000, 12, 1, 1, 1'b0);
    $display("[TB] input and start masking");
    runScan("masking", 64'h00FF_0000_0000_0000, 64'h0, 100, 8, 0, 1'b1);

    $display("[TB] reset mid-scan");
    whitePawns = 64'h0000_0000_0000_1000;
    blackPawns = 64'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.busy", int'(busy), 0);
    checkOutput("midReset.done", int'(done), 0);
    checkOutput("midReset.score", int'(score), 0);
    checkOutput("midReset.pawnCount", int'(pawnCount), 0);
    checkOutput("midReset.conflict", int'(conflict), 0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("midReset.noDone", dones, 0);
    runScan("afterReset", 64'h0000_0000_0000_1000, 64'h0, -32, 1, 0, 1'b0);

    $display("[TB] back-to-back");
    whitePawns = 64'h0000_0008_0000_0000;
    blackPawns = 64'h0;
    start = 1'b1;
    gap = 0;
    while (!done && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("b2b.firstLatency", gap, 66);
    checkOutput("b2b.firstScore", int'(score), 12);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 200);
    start = 1'b0;
    checkOutput("b2b.period", gap, 66);
    checkOutput("b2b.secondScore", int'(score), 12);
    repeat (3) @(negedge clk);
    checkOutput("b2b.idleAfter", int'(busy), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
